// File: rtl/flash_bist_if.sv
// flash_bist_if: request/acknowledge flash access bus between the BIST engine and the flash controller
interface flash_bist_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
);
  logic              mem_req;
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  modport master (output mem_req, mem_cmd, mem_addr, mem_wdata, input mem_ack, mem_rdata);
  modport slave  (input mem_req, mem_cmd, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/flash_bist.sv
// flash_bist: erase / program-pattern / read-compare self test over a flash word range with ack watchdog
module flash_bist #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 8,
  parameter int START_ADDR = 0,
  parameter int NUM_WORDS  = 256,
  parameter int TIMEOUT    = 65535
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [1:0]        mode,
  flash_bist_if.master      mem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [ADDR_W-1:0] fail_addr
);
  localparam int OFF_W = $clog2(NUM_WORDS + 1);
  localparam int WD_W  = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [OFF_W-1:0]  LAST = OFF_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(START_ADDR);
  localparam logic [DATA_W-1:0] P55  = DATA_W'(32'h5555_5555);
  typedef enum logic [2:0] {IDLE, ERASE, PROG, READ, DONE} state_t;
  state_t            state;
  logic              req;
  logic [1:0]        cmd;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [OFF_W-1:0]  off;
  logic [WD_W-1:0]   wd;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] cur_pat;
  logic              mis, last, ack;
  function automatic logic [DATA_W-1:0] pattern(input logic [1:0] m, input logic [OFF_W-1:0] o);
    logic [DATA_W-1:0] v;
    v = DATA_W'(o);
    return m == 2'd0 ? v : m == 2'd1 ? (o[0] ? ~P55 : P55) : m == 2'd2 ? ~v : '1;
  endfunction
  assign cur_pat       = pattern(mode_q, off);
  assign mis           = mem.mem_rdata != cur_pat;
  assign last          = off == LAST;
  assign ack           = req && mem.mem_ack;
  assign mem.mem_req   = req;
  assign mem.mem_cmd   = cmd;
  assign mem.mem_addr  = addr;
  assign mem.mem_wdata = wdata;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= IDLE;
      req       <= 1'b0;
      cmd       <= 2'b00;
      addr      <= '0;
      wdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      err_cnt   <= '0;
      fail_addr <= '0;
      wd        <= '0;
      off       <= '0;
      mode_q    <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          mode_q    <= mode;
          done      <= 1'b0;
          pass      <= 1'b0;
          timeout   <= 1'b0;
          err_cnt   <= '0;
          fail_addr <= '0;
          busy      <= 1'b1;
          off       <= '0;
          state     <= ERASE;
        end
        default: if (!req) begin
          // a launch only happens from a low request, so every request is preceded by an idle cycle
          req   <= 1'b1;
          wd    <= '0;
          cmd   <= state == ERASE ? 2'b01 : state == PROG ? 2'b10 : 2'b11;
          addr  <= state == ERASE ? BASE : BASE + ADDR_W'(off);
          wdata <= state == PROG ? cur_pat : '0;
        end else if (ack) begin
          req <= 1'b0;
          off <= (last || state == ERASE) ? '0 : off + OFF_W'(1);
          if (state == READ && mis) begin
            err_cnt <= &err_cnt ? err_cnt : err_cnt + 16'd1;
            if (err_cnt == '0) fail_addr <= addr;
          end
          if (state == ERASE) state <= PROG;
          else if (last) state <= state == PROG ? READ : DONE;
          if (state == READ && last) begin
            cmd  <= 2'b00;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= err_cnt == '0 && !mis;
          end
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          req     <= 1'b0;
          cmd     <= 2'b00;
          timeout <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b1;
          pass    <= 1'b0;
          state   <= DONE;
        end else begin
          wd <= wd + WD_W'(1);
        end
      endcase
    end
  end
endmodule

// File: tb/tb_flash_bist.sv
// tb_flash_bist: directed and randomized runs of flash_bist against an echo flash model and a transaction-level reference
module tb_flash_bist;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int SA = 'h100;
  localparam int NW = 4;
  localparam int TO = 50;
  typedef struct packed {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;
  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          busy, done, pass, timeout;
  logic [15:0]   err_cnt;
  logic [AW-1:0] fail_addr;
  int checks = 0;
  int errors = 0;
  flash_bist_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();
  flash_bist #(.ADDR_W(AW), .DATA_W(DW), .START_ADDR(SA), .NUM_WORDS(NW), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .mode(mode), .mem(mem_bus.master),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt), .fail_addr(fail_addr)
  );
  always #5 sys_clk = ~sys_clk;
  txn_t          log_q[$];
  logic [DW-1:0] fmem [0:(1<<AW)-1];
  int            lat = 0, wcnt = 0, run = 0, last_run = 0, nreq = 0, prot_viol = 0;
  bit            no_ack = 0, cor_en = 0, prev_req = 0, prev_ack = 0;
  logic [AW-1:0] cor_addr = '0;
  logic [DW-1:0] cor_val = '0;
  txn_t          prev_t = '0;
  always @(negedge sys_clk) begin
    txn_t t;
    t = '{mem_bus.mem_cmd, mem_bus.mem_addr, mem_bus.mem_wdata};
    if (prev_ack && mem_bus.mem_req) prot_viol++;
    if (mem_bus.mem_req && prev_req && t != prev_t) prot_viol++;
    if (mem_bus.mem_req && t.cmd == 2'b00) prot_viol++;
    if (mem_bus.mem_req && !prev_req) nreq++;
    run = mem_bus.mem_req ? run + 1 : 0;
    if (mem_bus.mem_req) last_run = run;
    mem_bus.mem_ack = 1'b0;
    if (mem_bus.mem_req && !no_ack) begin
      if (wcnt >= lat) begin
        mem_bus.mem_ack = 1'b1;
        wcnt = 0;
        log_q.push_back(t);
        case (t.cmd)
          2'b01:   for (int i = 0; i < (1 << AW); i++) fmem[i] = '1;
          2'b10:   fmem[t.addr] = t.wdata;
          default: mem_bus.mem_rdata = (cor_en && t.addr == cor_addr) ? cor_val : fmem[t.addr];
        endcase
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
    prev_ack = mem_bus.mem_ack;
    prev_req = mem_bus.mem_req;
    prev_t   = t;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] pat(input int m, input int off);
    logic [DW-1:0] v;
    v = DW'(off);
    case (m)
      0:       return v;
      1:       return (off % 2) ? 8'hAA : 8'h55;
      2:       return ~v;
      default: return 8'hFF;
    endcase
  endfunction
  task automatic pulse_start(input logic [1:0] m);
    @(negedge sys_clk);
    log_q.delete();
    prot_viol = 0;
    nreq = 0;
    mode = m;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    chk({tag, "_done"}, done, 1);
  endtask
  task automatic wait_req(input string tag, input logic [1:0] c, input logic [AW-1:0] a, input bit any_addr);
    int n = 0;
    while (!(mem_bus.mem_req && mem_bus.mem_cmd == c && (any_addr || mem_bus.mem_addr == a)) && n < 500) begin
      @(negedge sys_clk);
      n++;
    end
    chk({tag, "_seen"}, n < 500, 1);
  endtask
  task automatic check_run(input string tag, input int m, input int exp_err, input logic [AW-1:0] exp_fail);
    txn_t e[$];
    e.push_back('{2'b01, AW'(SA), '0});
    for (int i = 0; i < NW; i++) e.push_back('{2'b10, AW'(SA + i), pat(m, i)});
    for (int i = 0; i < NW; i++) e.push_back('{2'b11, AW'(SA + i), '0});
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_err_cnt"}, err_cnt, exp_err);
    chk({tag, "_pass"}, pass, exp_err == 0);
    chk({tag, "_fail_addr"}, fail_addr, exp_fail);
    chk({tag, "_protocol"}, prot_viol, 0);
    chk({tag, "_ntxn"}, log_q.size(), e.size());
    for (int i = 0; i < e.size() && i < log_q.size(); i++) begin
      txn_t g;
      g = log_q[i];
      if (e[i].cmd != 2'b10) g.wdata = '0;
      chk($sformatf("%s_txn%0d", tag, i), g, e[i]);
    end
  endtask
  initial begin
    int m, off, exp_err;
    repeat (3) @(negedge sys_clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_fail_addr", fail_addr, 0);
    chk("rst_req", mem_bus.mem_req, 0);
    chk("rst_cmd", mem_bus.mem_cmd, 0);
    chk("rst_addr", mem_bus.mem_addr, 0);
    chk("rst_wdata", mem_bus.mem_wdata, 0);
    sys_rst = 1'b0;
    lat = 0;
    pulse_start(2'd0);
    wait_done("m0");
    check_run("m0", 0, 0, '0);
    cor_en = 1;
    cor_addr = AW'(SA + 2);
    cor_val = 8'h00;
    pulse_start(2'd1);
    wait_done("m1c");
    check_run("m1c", 1, 1, AW'(SA + 2));
    cor_en = 0;
    no_ack = 1;
    pulse_start(2'd0);
    wait_done("to");
    chk("to_timeout", timeout, 1);
    chk("to_pass", pass, 0);
    chk("to_busy", busy, 0);
    chk("to_req", mem_bus.mem_req, 0);
    chk("to_req_cycles", last_run, TO);
    chk("to_nreq", nreq, 1);
    chk("to_ntxn", log_q.size(), 0);
    no_ack = 0;
    lat = 3;
    pulse_start(2'd2);
    wait_req("rst_mid", 2'b10, AW'(SA + 2), 0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    chk("rstm_req", mem_bus.mem_req, 0);
    chk("rstm_cmd", mem_bus.mem_cmd, 0);
    chk("rstm_addr", mem_bus.mem_addr, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_status", {done, pass, timeout}, 0);
    chk("rstm_err_cnt", err_cnt, 0);
    repeat (6) @(negedge sys_clk);
    chk("rstm_still_idle", {mem_bus.mem_req, busy}, 0);
    m = $urandom_range(0, 3);
    pulse_start(2'(m));
    wait_done("rstm_rerun");
    check_run("rstm_rerun", m, 0, '0);
    lat = 0;
    pulse_start(2'd0);
    mode = 2'd3;
    wait_req("ign_prog", 2'b10, '0, 1);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_req("ign_last", 2'b11, AW'(SA + NW - 1), 0);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    wait_done("ign");
    repeat (5) @(negedge sys_clk);
    check_run("ign", 0, 0, '0);
    lat = 3;
    pulse_start(2'd3);
    wait_done("m3l");
    check_run("m3l", 3, 0, '0);
    for (int r = 0; r < 6; r++) begin
      m = $urandom_range(0, 3);
      lat = $urandom_range(0, 4);
      cor_en = 1'($urandom_range(0, 1));
      off = $urandom_range(0, NW - 1);
      cor_addr = AW'(SA + off);
      cor_val = DW'($urandom);
      exp_err = (cor_en && cor_val != pat(m, off)) ? 1 : 0;
      pulse_start(2'(m));
      wait_done($sformatf("rnd%0d", r));
      check_run($sformatf("rnd%0d", r), m, exp_err, exp_err != 0 ? cor_addr : '0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
